branch_predictor: RTL
=====================

# branch_predictor

Fetch-side dynamic branch predictor with a direct-mapped branch target buffer (BTB) and a 2-bit saturating counter per entry. It sits between the fetch PC and the next-PC mux. Each cycle it gives a taken/not-taken prediction and a target for the current fetch PC. It is trained by the resolved outcome from `branch_cond` (`br_taken`) plus the resolved target, and it flags mispredictions so the PC logic can redirect.

## Interface
Parameters:
- `IDX_W`, default 6: index width; the table has 2^IDX_W entries, indexed by `pc[IDX_W+1:2]`.
- `TAG_W`, default 32-IDX_W-2: tag width, taken from `pc[31:IDX_W+2]`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `if_pc`, in, 32: current fetch PC (lookup address).
- `pred_hit`, out, 1: BTB entry valid and tag matches `if_pc`.
- `pred_taken`, out, 1: predicted taken.
- `pred_target`, out, 32: predicted next PC.
- `upd_valid`, in, 1: a resolved conditional branch is presented this cycle.
- `upd_pc`, in, 32: PC of the resolved branch.
- `upd_br_taken`, in, 1: actual outcome (the `br_taken` of `branch_cond`).
- `upd_target`, in, 32: actual branch target (PC+imm).
- `upd_pred_taken`, in, 1: prediction issued for this branch at fetch.
- `upd_pred_target`, in, 32: target issued for this branch at fetch.
- `mispredict`, out, 1: prediction was wrong; redirect required.
- `mispred_count`, out, 32: number of mispredictions since reset, saturating.

## Operation
- Counter encoding: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11. Taken when bit[1]=1.
- Each entry holds `valid`, `tag[TAG_W]`, `target[32]` and `ctr[2]`.
- Lookup (combinational on `if_pc`):
  - `pred_hit` = valid & tag match.
  - `pred_taken` = `pred_hit` & ctr[1].
  - `pred_target` = `pred_taken` ? target : `if_pc`+4.
- Update when `upd_valid`=1, indexed and tagged by `upd_pc`:
  - Hit, taken: ctr increments, saturating at ST, and target is written with `upd_target`.
  - Hit, not taken: ctr decrements, saturating at SNT. Target is unchanged.
  - Miss, taken: allocate the entry (overwriting any previous occupant): valid=1, tag, target=`upd_target`, ctr=WT.
  - Miss, not taken: no table change.
- `mispredict` = `upd_valid` & ((`upd_br_taken` != `upd_pred_taken`) | (`upd_br_taken` & `upd_pred_taken` & (`upd_target` != `upd_pred_target`))).
- `mispred_count` increments by 1 on each cycle with `mispredict`=1 and holds at 32'hFFFF_FFFF.
- `upd_valid`=0: no state changes and `mispredict`=0.
- PC arithmetic is modulo 2^32: `if_pc`=32'hFFFF_FFFC gives a not-taken `pred_target` of 0.

## Timing
- Lookup: zero latency, combinational from `if_pc` and current state.
- Update: takes effect at the rising edge after `upd_valid`. The first lookup that observes it is in the next cycle.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update state. There is no bypass.
- `mispredict` is combinational, valid in the same cycle as `upd_valid`.
- Reset (asynchronous assert, any time, including mid-update):
  - All valid bits=0, all ctr=WNT, tags and targets=0, `mispred_count`=0.
  - Outputs then read `pred_hit`=0, `pred_taken`=0, `pred_target`=`if_pc`+4, `mispredict`=0 while `upd_valid`=0.
  - An update in flight at reset assertion is discarded.
- Deassertion is synchronised externally. The first update is accepted at the first rising edge with `rst_n`=1.

## Structure
- Package `bp_pkg` holds:
  - `ctr_t` enum {SNT, WNT, WT, ST}.
  - Constants `CTR_RESET`=WNT and `CTR_ALLOC`=WT.
  - The entry struct type (valid, tag, target, ctr).
- Sub-module `bp_sat_ctr`: combinational 2-bit saturating next-state function (inputs `ctr_t`, taken; output `ctr_t`). It is instantiated once, on the update path.
- The table is a flop array with asynchronous reset, not an SRAM, so the reset contents above are guaranteed.

## Test plan
- **Reset defaults:** assert `rst_n`=0, drive `if_pc`=32'h100 -> `pred_hit`=0, `pred_taken`=0, `pred_target`=32'h104, `mispred_count`=0.
- **Allocation:** update `upd_pc`=32'h100, `upd_br_taken`=1, `upd_target`=32'h80, `upd_pred_taken`=0.
  - Same cycle: `mispredict`=1.
  - Next cycle, lookup 32'h100: `pred_hit`=1, `pred_taken`=1, `pred_target`=32'h80, and `mispred_count`=1.
- **Saturation and hysteresis:** after allocation, three taken updates (ctr=ST), then one not-taken update -> ctr=WT and the prediction stays taken. A second not-taken update -> ctr=WNT, `pred_taken`=0, `pred_target`=32'h104. Five more not-taken updates -> ctr stays SNT.
- **Alias eviction:** with 32'h100 allocated, a taken update at 32'h100 + (1<<(IDX_W+2)) -> the old entry is replaced and lookup of 32'h100 gives `pred_hit`=0. A not-taken miss at a fresh index leaves `pred_hit`=0.
- **Same-cycle conflict and target mismatch:**
  - Lookup and update of the same index in one cycle -> the lookup shows the old ctr.
  - `upd_br_taken`=1, `upd_pred_taken`=1, `upd_pred_target`=32'h80, `upd_target`=32'h90 -> `mispredict`=1, and the stored target becomes 32'h90.
- **Counter saturation and mid-run reset:**
  - Force `mispred_count` to 32'hFFFF_FFFE and apply 3 mispredicts -> the count holds at 32'hFFFF_FFFF.
  - Assert `rst_n` asynchronously between edges during an update -> all state returns to the reset defaults immediately, and the update is not written.

Source files
------------

// File: rtl/bp_pkg.sv
// ============================================================================
//  Module   : bp_pkg
//  Purpose  : Shared types and constants for the BTB-based branch predictor.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    // Tags are stored zero-extended to the widest possible tag (IDX_W >= 0).
    localparam int MAX_TAG_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
    } bp_entry_t;

endpackage : bp_pkg

`default_nettype wire

// File: rtl/bp_sat_ctr.sv
// ============================================================================
//  Module   : bp_sat_ctr
//  Purpose  : 2-bit saturating counter next-state function.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module bp_sat_ctr
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        unique case (ctr)
            SNT: ctr_next = taken ? WNT : SNT;
            WNT: ctr_next = taken ? WT  : SNT;
            WT:  ctr_next = taken ? ST  : WNT;
            ST:  ctr_next = taken ? ST  : WT;
            default: ctr_next = ctr;
        endcase
    end

endmodule : bp_sat_ctr

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Direct-mapped BTB with 2-bit counters; lookup, training, mispredict.
//  Revision : 1.0  - initial release
// ============================================================================
`default_nettype none

module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_br_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] mispred_count
);

    localparam int c_NUM_ENTRIES = 1 << IDX_W;

    bp_entry_t r_table [c_NUM_ENTRIES];
    logic [31:0] r_mispred_count;

    logic [IDX_W-1:0]     w_lk_idx;
    logic [MAX_TAG_W-1:0] w_lk_tag;
    bp_entry_t            w_lk_entry;
    logic [IDX_W-1:0]     w_up_idx;
    logic [MAX_TAG_W-1:0] w_up_tag;
    bp_entry_t            w_up_entry;
    logic                 w_up_hit;
    ctr_t                 w_ctr_next;
    logic                 w_unused;

    assign w_lk_idx   = if_pc[IDX_W+1:2];
    assign w_lk_tag   = MAX_TAG_W'(if_pc[IDX_W+2 +: TAG_W]);
    assign w_lk_entry = r_table[w_lk_idx];
    assign w_up_idx   = upd_pc[IDX_W+1:2];
    assign w_up_tag   = MAX_TAG_W'(upd_pc[IDX_W+2 +: TAG_W]);
    assign w_up_entry = r_table[w_up_idx];
    assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);
    assign w_unused   = ^{if_pc[1:0], upd_pc[1:0]};

    assign pred_hit    = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
    assign pred_taken  = pred_hit && w_lk_entry.ctr[1];
    assign pred_target = pred_taken ? w_lk_entry.target : (if_pc + 32'd4);

    // A correctly-predicted-taken branch still mispredicts if it went elsewhere.
    assign mispredict = upd_valid &&
                        ((upd_br_taken != upd_pred_taken) ||
                         (upd_br_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    assign mispred_count = r_mispred_count;

    bp_sat_ctr u_sat_ctr (
        .ctr      (w_up_entry.ctr),
        .taken    (upd_br_taken),
        .ctr_next (w_ctr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_ENTRIES; i++) begin
                r_table[i].valid  <= 1'b0;
                r_table[i].tag    <= '0;
                r_table[i].target <= '0;
                r_table[i].ctr    <= CTR_RESET;
            end
            r_mispred_count <= '0;
        end else begin
            if (upd_valid) begin
                if (w_up_hit) begin
                    r_table[w_up_idx].ctr <= w_ctr_next;
                    if (upd_br_taken) begin
                        r_table[w_up_idx].target <= upd_target;
                    end
                end else if (upd_br_taken) begin
                    r_table[w_up_idx].valid  <= 1'b1;
                    r_table[w_up_idx].tag    <= w_up_tag;
                    r_table[w_up_idx].target <= upd_target;
                    r_table[w_up_idx].ctr    <= CTR_ALLOC;
                end
            end
            if (mispredict && (r_mispred_count != 32'hFFFF_FFFF)) begin
                r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

endmodule : branch_predictor

`default_nettype wire
